// File: rtl/run_host.sv
// Host-side run controller: streams a load window into data memory, launches the core via
// a req/done handshake with timeout, then drains a result window to an output stream.
module run_host #(
   parameter int DW       = 8,
   parameter int AW       = 8,
   parameter int LD_BASE  = 0,
   parameter int LD_LEN   = 32,
   parameter int RES_BASE = 64,
   parameter int RES_LEN  = 32,
   parameter int TMO_W    = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   output logic          core_reset,
   output logic          req,
   input  logic          done,
   output logic          mem_sel,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          busy,
   output logic          fin,
   output logic          err
);

   localparam int IW = 32;
   localparam logic [IW-1:0] LD_LAST  = IW'(LD_LEN - 1);
   localparam logic [IW-1:0] RES_LAST = IW'(RES_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_REQ, S_WAIT, S_DRAIN, S_FIN
   } state_t;

   state_t           state, state_n;
   logic [IW-1:0]    idx, idx_n;
   logic [TMO_W-1:0] tmo, tmo_n;
   logic             err_n;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         idx   <= '0;
         tmo   <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         tmo   <= tmo_n;
         err   <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      tmo_n      = tmo;
      err_n      = err;
      core_reset = 1'b1;
      mem_sel    = 1'b1;
      req        = 1'b0;
      ld_ready   = 1'b0;
      mem_wr_en  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      out_valid  = 1'b0;
      out_data   = '0;
      fin        = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start) begin
               err_n   = 1'b0;
               idx_n   = '0;
               state_n = (LD_LEN == 0) ? S_REQ : S_LOAD;
            end
         end
         S_LOAD: begin
            ld_ready  = 1'b1;
            mem_addr  = AW'(LD_BASE + idx);
            mem_wdata = ld_data;
            mem_wr_en = ld_valid;
            if (ld_valid) begin
               if (idx == LD_LAST) begin
                  idx_n   = '0;
                  state_n = S_REQ;
               end else begin
                  idx_n = idx + 1;
               end
            end
         end
         S_REQ: begin
            core_reset = 1'b0;
            mem_sel    = 1'b0;
            req        = 1'b1;
            tmo_n      = '0;
            state_n    = S_WAIT;
         end
         S_WAIT: begin
            core_reset = 1'b0;
            mem_sel    = 1'b0;
            tmo_n      = tmo + 1'b1;
            // done on the expiry cycle still counts as success
            if (done) begin
               state_n = (RES_LEN == 0) ? S_FIN : S_DRAIN;
            end else if (tmo == '1) begin
               err_n   = 1'b1;
               state_n = S_IDLE;
            end
         end
         S_DRAIN: begin
            core_reset = 1'b0;
            mem_addr   = AW'(RES_BASE + idx);
            out_valid  = 1'b1;
            out_data   = mem_rdata;
            if (out_ready) begin
               if (idx == RES_LAST) begin
                  idx_n   = '0;
                  state_n = S_FIN;
               end else begin
                  idx_n = idx + 1;
               end
            end
         end
         S_FIN: begin
            fin     = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_run_host.sv
// Self-checking bench for run_host: scenario tasks with randomized load data, gaps,
// done delays and output stalls, checked against expected stream/memory contents.
module tb_run_host;
   localparam int DW = 8, AW = 8, LD_BASE = 0, LD_LEN = 4;
   localparam int RES_BASE = 64, RES_LEN = 2, TMO_W = 4;
   localparam int TMO_CYC = 2**TMO_W;

   logic clk = 0, reset = 0, start = 0, ld_valid = 0, done = 0, out_ready = 0;
   logic [DW-1:0] ld_data = '0;
   logic          ld_ready, core_reset, req, mem_sel, mem_wr_en, out_valid, busy, fin, err;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata, out_data;

   logic [DW-1:0] wmem [0:2**AW-1];
   logic [DW-1:0] rmem [0:2**AW-1];
   logic [DW-1:0] ld_ref [0:2**AW-1];
   int vectors = 0, miscompares = 0;

   // {core_reset, mem_sel, req, ld_ready, mem_wr_en, out_valid, busy, fin, err}
   wire [8:0] ctl = {core_reset, mem_sel, req, ld_ready, mem_wr_en, out_valid, busy, fin, err};

   run_host #(.DW(DW), .AW(AW), .LD_BASE(LD_BASE), .LD_LEN(LD_LEN), .RES_BASE(RES_BASE),
              .RES_LEN(RES_LEN), .TMO_W(TMO_W)) dut (
      .clk(clk), .reset(reset), .start(start), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .core_reset(core_reset), .req(req), .done(done), .mem_sel(mem_sel),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy),
      .fin(fin), .err(err));

   always #5 clk = ~clk;
   assign mem_rdata = rmem[mem_addr];
   always @(posedge clk) if (mem_wr_en === 1'b1) wmem[mem_addr] <= mem_wdata;

   always @(negedge clk) begin
      vectors++;
      if (mem_wr_en === 1'b1 && mem_sel !== 1'b1) begin
         miscompares++;
         $display("FAIL wr_without_sel got mem_sel=%b exp 1", mem_sel);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1);
   end

   task automatic load_phase(input bit gaps, input logic exp_err);
      logic [DW-1:0] d;
      @(negedge clk); start = 1; #1;
      vectors++;
      if (ctl !== {8'b1100_0000, exp_err}) begin
         miscompares++; $display("FAIL idle_pre_start got %b exp %b", ctl, {8'b1100_0000, exp_err});
      end
      @(negedge clk); start = 0;
      for (int i = 0; i < LD_LEN; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin
            ld_valid = 0; #1;
            vectors++;
            if (ctl !== 9'b110100100) begin
               miscompares++; $display("FAIL load_gap got %b exp %b", ctl, 9'b110100100);
            end
            @(negedge clk);
         end
         d = DW'($urandom); ld_valid = 1; ld_data = d; #1;
         vectors++;
         if ({ctl, mem_addr, mem_wdata} !== {9'b110110100, AW'(LD_BASE + i), d}) begin
            miscompares++;
            $display("FAIL load_accept i=%0d got %b/%h/%h exp %b/%h/%h", i, ctl, mem_addr,
                     mem_wdata, 9'b110110100, AW'(LD_BASE + i), d);
         end
         ld_ref[AW'(LD_BASE + i)] = d;
         @(negedge clk);
      end
      ld_valid = 0; ld_data = '0; #1;
      vectors++;
      if (ctl !== 9'b001000100) begin
         miscompares++; $display("FAIL req_cycle got %b exp %b", ctl, 9'b001000100);
      end
      @(negedge clk);
      for (int i = 0; i < LD_LEN; i++) begin
         vectors++;
         if (wmem[AW'(LD_BASE + i)] !== ld_ref[AW'(LD_BASE + i)]) begin
            miscompares++;
            $display("FAIL mem_write addr=%h got %h exp %h", AW'(LD_BASE + i),
                     wmem[AW'(LD_BASE + i)], ld_ref[AW'(LD_BASE + i)]);
         end
      end
   endtask

   // WAIT cycles 0..n, done raised on cycle n, optional start pulse on cycle start_at
   task automatic wait_phase(input int n, input int start_at);
      for (int c = 0; c <= n; c++) begin
         done = (c == n); start = (c == start_at); #1;
         vectors++;
         if (ctl !== 9'b000000100) begin
            miscompares++; $display("FAIL wait c=%0d got %b exp %b", c, ctl, 9'b000000100);
         end
         @(negedge clk);
      end
      done = 0; start = 0;
   endtask

   task automatic drain_phase(input int stall_lo, input int stall_hi);
      logic [AW-1:0] a;
      for (int i = 0; i < RES_LEN; i++) begin
         a = AW'(RES_BASE + i);
         repeat ($urandom_range(stall_lo, stall_hi)) begin
            out_ready = 0; #1;
            vectors++;
            if ({ctl, mem_addr, out_data} !== {9'b010001100, a, rmem[a]}) begin
               miscompares++;
               $display("FAIL drain_stall i=%0d got %b/%h/%h exp %b/%h/%h", i, ctl, mem_addr,
                        out_data, 9'b010001100, a, rmem[a]);
            end
            @(negedge clk);
         end
         out_ready = 1; #1;
         vectors++;
         if ({ctl, mem_addr, out_data} !== {9'b010001100, a, rmem[a]}) begin
            miscompares++;
            $display("FAIL drain_accept i=%0d got %b/%h/%h exp %b/%h/%h", i, ctl, mem_addr,
                     out_data, 9'b010001100, a, rmem[a]);
         end
         @(negedge clk);
      end
      out_ready = 0; #1;
      vectors++;
      if ({fin, core_reset, busy, out_valid, req, mem_wr_en} !== 6'b111000) begin
         miscompares++;
         $display("FAIL fin_cycle got %b exp %b", {fin, core_reset, busy, out_valid, req, mem_wr_en},
                  6'b111000);
      end
      @(negedge clk); #1;
      vectors++;
      if (ctl !== 9'b110000000) begin
         miscompares++; $display("FAIL post_fin_idle got %b exp %b", ctl, 9'b110000000);
      end
   endtask

   task automatic preload_results();
      for (int i = 0; i < RES_LEN; i++) rmem[AW'(RES_BASE + i)] = DW'($urandom);
   endtask

   task automatic test_reset();
      reset = 0;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({ctl, mem_addr} !== {9'b110000000, AW'(0)}) begin
         miscompares++; $display("FAIL reset_state got %b/%h exp %b/00", ctl, mem_addr, 9'b110000000);
      end
      reset = 1;
   endtask

   task automatic test_back_to_back();
      rmem[AW'(RES_BASE)] = 8'h5A; rmem[AW'(RES_BASE + 1)] = 8'hC3;
      load_phase(0, 0);
      wait_phase(9, -1);
      drain_phase(0, 0);
   endtask

   task automatic test_stall();
      preload_results();
      load_phase(1, 0);
      wait_phase(3, -1);
      drain_phase(3, 3);
   endtask

   task automatic test_timeout();
      load_phase(0, 0);
      for (int c = 0; c < TMO_CYC; c++) begin
         done = 0; #1;
         vectors++;
         if (ctl !== 9'b000000100) begin
            miscompares++; $display("FAIL tmo_wait c=%0d got %b exp %b", c, ctl, 9'b000000100);
         end
         @(negedge clk);
      end
      #1;
      vectors++;
      if (ctl !== 9'b110000001) begin
         miscompares++; $display("FAIL timeout_idle got %b exp %b", ctl, 9'b110000001);
      end
      @(negedge clk); #1;
      vectors++;
      if (ctl !== 9'b110000001) begin
         miscompares++; $display("FAIL err_sticky got %b exp %b", ctl, 9'b110000001);
      end
      preload_results();
      load_phase(1, 1);
      wait_phase(2, -1);
      drain_phase(0, 1);
   endtask

   task automatic test_reset_midload();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1; ld_data = DW'($urandom);
         @(negedge clk);
      end
      ld_valid = 0; reset = 0;
      @(negedge clk); #1;
      vectors++;
      if ({ctl, mem_addr} !== {9'b110000000, AW'(0)}) begin
         miscompares++;
         $display("FAIL midload_reset got %b/%h exp %b/00", ctl, mem_addr, 9'b110000000);
      end
      reset = 1;
      preload_results();
      load_phase(0, 0);
      wait_phase(int'($urandom_range(0, TMO_CYC - 1)), -1);
      drain_phase(0, 1);
   endtask

   task automatic test_done_wins();
      preload_results();
      load_phase(1, 0);
      wait_phase(TMO_CYC - 1, 5);
      drain_phase(0, 0);
      @(negedge clk); #1;
      vectors++;
      if (ctl !== 9'b110000000) begin
         miscompares++; $display("FAIL start_ignored got %b exp %b", ctl, 9'b110000000);
      end
   endtask

   task automatic test_random();
      repeat (6) begin
         preload_results();
         load_phase(1, 0);
         wait_phase(int'($urandom_range(0, TMO_CYC - 1)), -1);
         drain_phase(0, 3);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_timeout();
      test_reset_midload();
      test_done_wins();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
